// File: rtl/fei4_cmd_decoder.sv
// FE-I4 serial command decoder.
// Turns the CMD_DATA bit stream into trigger, fast and slow command outputs.
module fei4_cmd_decoder #(
    parameter int WR_FE_BITS = 672
) (
    input  logic        CMD_CLK,
    input  logic        RST_B,
    input  logic        CMD_DATA,
    input  logic [2:0]  CHIP_ID,
    output logic        LV1,
    output logic        BCR,
    output logic        ECR,
    output logic        CAL,
    output logic        SLOW_VALID,
    output logic [3:0]  SLOW_CMD,
    output logic [5:0]  SLOW_ADDR,
    output logic [15:0] SLOW_DATA,
    output logic [15:0] FE_DATA,
    output logic        FE_DATA_VALID,
    output logic        FE_DATA_LAST,
    output logic        RUN_MODE,
    output logic        BUSY,
    output logic        CMD_ERR,
    output logic [7:0]  ERR_CNT
);

    localparam int NWORDS = WR_FE_BITS / 16;
    localparam int WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);

    localparam logic [3:0] C_RD_REG  = 4'b0001;
    localparam logic [3:0] C_WR_REG  = 4'b0010;
    localparam logic [3:0] C_WR_FE   = 4'b0100;
    localparam logic [3:0] C_GRST    = 4'b1000;
    localparam logic [3:0] C_GPULSE  = 4'b1001;
    localparam logic [3:0] C_RUNMODE = 4'b1010;

    typedef enum logic [2:0] {
        IDLE, FIELD2, SLOW_HDR, DATA16, DATAFE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       win_q, win_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [14:0]      sr_q, sr_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [3:0]       pcmd_q, pcmd_d;
    logic [5:0]       paddr_q, paddr_d;
    logic             match_q, match_d;
    logic             lv1_q, lv1_d;
    logic             bcr_q, bcr_d;
    logic             ecr_q, ecr_d;
    logic             cal_q, cal_d;
    logic             slow_valid_q, slow_valid_d;
    logic [3:0]       slow_cmd_q, slow_cmd_d;
    logic [5:0]       slow_addr_q, slow_addr_d;
    logic [15:0]      slow_data_q, slow_data_d;
    logic [15:0]      fe_data_q, fe_data_d;
    logic             fe_valid_q, fe_valid_d;
    logic             fe_last_q, fe_last_d;
    logic             run_mode_q, run_mode_d;
    logic             cmd_err_q, cmd_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [4:0]  win_next;
    logic [3:0]  f2;
    logic [13:0] hdr;
    logic [15:0] word;
    logic        hdr_match;
    logic        done;
    logic        err;
    logic [3:0]  c_cmd;
    logic [5:0]  c_addr;
    logic [15:0] c_data;
    logic        c_match;

    // Fields always end on the bit being sampled this cycle.
    assign win_next  = {win_q, CMD_DATA};
    assign f2        = {sr_q[2:0], CMD_DATA};
    assign hdr       = {sr_q[12:0], CMD_DATA};
    assign word      = {sr_q, CMD_DATA};
    assign hdr_match = hdr[9] | (hdr[8:6] == CHIP_ID);

    // Next-state and registered-output logic for the command decoder.
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        cnt_d        = cnt_q + 4'd1;
        sr_d         = {sr_q[13:0], CMD_DATA};
        wcnt_d       = wcnt_q;
        pcmd_d       = pcmd_q;
        paddr_d      = paddr_q;
        match_d      = match_q;
        lv1_d        = 1'b0;
        bcr_d        = 1'b0;
        ecr_d        = 1'b0;
        cal_d        = 1'b0;
        slow_valid_d = 1'b0;
        slow_cmd_d   = slow_cmd_q;
        slow_addr_d  = slow_addr_q;
        slow_data_d  = slow_data_q;
        fe_data_d    = fe_data_q;
        fe_valid_d   = 1'b0;
        fe_last_d    = 1'b0;
        run_mode_d   = run_mode_q;
        cmd_err_d    = 1'b0;
        err_cnt_d    = err_cnt_q;
        done         = 1'b0;
        err          = 1'b0;
        c_cmd        = pcmd_q;
        c_addr       = paddr_q;
        c_match      = match_q;
        c_data       = 16'h0000;

        unique case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (win_next == 5'b11101) begin
                    lv1_d = 1'b1;
                    win_d = 4'd0;
                end else if (win_next == 5'b10110) begin
                    state_d = FIELD2;
                    win_d   = 4'd0;
                end else begin
                    win_d = win_next[3:0];
                end
            end
            FIELD2: begin
                if (cnt_q == 4'd3) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                    case (f2)
                        4'b0001: bcr_d = 1'b1;
                        4'b0010: ecr_d = 1'b1;
                        4'b0100: cal_d = 1'b1;
                        4'b1000: state_d = SLOW_HDR;
                        default: err = 1'b1;
                    endcase
                end
            end
            SLOW_HDR: begin
                if (cnt_q == 4'd13) begin
                    cnt_d   = 4'd0;
                    pcmd_d  = hdr[13:10];
                    paddr_d = hdr[5:0];
                    match_d = hdr_match;
                    c_cmd   = hdr[13:10];
                    c_addr  = hdr[5:0];
                    c_match = hdr_match;
                    case (hdr[13:10])
                        C_RD_REG, C_GRST, C_GPULSE: done = 1'b1;
                        C_RUNMODE: begin
                            if (hdr[5:0] == 6'b111000) begin
                                done = 1'b1;
                                if (hdr_match) run_mode_d = 1'b1;
                            end else if (hdr[5:0] == 6'b000111) begin
                                done = 1'b1;
                                if (hdr_match) run_mode_d = 1'b0;
                            end else begin
                                err = 1'b1;
                            end
                        end
                        C_WR_REG: state_d = DATA16;
                        C_WR_FE: begin
                            state_d = DATAFE;
                            wcnt_d  = '0;
                        end
                        default: err = 1'b1;
                    endcase
                end
            end
            DATA16: begin
                if (cnt_q == 4'd15) begin
                    c_data = word;
                    done   = 1'b1;
                end
            end
            DATAFE: begin
                if (cnt_q == 4'd15) begin
                    if (match_q) begin
                        fe_valid_d = 1'b1;
                        fe_data_d  = word;
                        fe_last_d  = (wcnt_q == LAST_WORD);
                    end
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == LAST_WORD) done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d = IDLE;
            win_d   = 4'd0;
            if (c_match) begin
                slow_valid_d = 1'b1;
                slow_cmd_d   = c_cmd;
                slow_addr_d  = c_addr;
                slow_data_d  = c_data;
                if (c_cmd == C_GRST) run_mode_d = 1'b0;
            end
        end

        if (err) begin
            state_d   = IDLE;
            win_d     = 4'd0;
            cmd_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge CMD_CLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q      <= IDLE;
            win_q        <= '0;
            cnt_q        <= '0;
            sr_q         <= '0;
            wcnt_q       <= '0;
            pcmd_q       <= '0;
            paddr_q      <= '0;
            match_q      <= 1'b0;
            lv1_q        <= 1'b0;
            bcr_q        <= 1'b0;
            ecr_q        <= 1'b0;
            cal_q        <= 1'b0;
            slow_valid_q <= 1'b0;
            slow_cmd_q   <= '0;
            slow_addr_q  <= '0;
            slow_data_q  <= '0;
            fe_data_q    <= '0;
            fe_valid_q   <= 1'b0;
            fe_last_q    <= 1'b0;
            run_mode_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            sr_q         <= sr_d;
            wcnt_q       <= wcnt_d;
            pcmd_q       <= pcmd_d;
            paddr_q      <= paddr_d;
            match_q      <= match_d;
            lv1_q        <= lv1_d;
            bcr_q        <= bcr_d;
            ecr_q        <= ecr_d;
            cal_q        <= cal_d;
            slow_valid_q <= slow_valid_d;
            slow_cmd_q   <= slow_cmd_d;
            slow_addr_q  <= slow_addr_d;
            slow_data_q  <= slow_data_d;
            fe_data_q    <= fe_data_d;
            fe_valid_q   <= fe_valid_d;
            fe_last_q    <= fe_last_d;
            run_mode_q   <= run_mode_d;
            cmd_err_q    <= cmd_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign LV1           = lv1_q;
    assign BCR           = bcr_q;
    assign ECR           = ecr_q;
    assign CAL           = cal_q;
    assign SLOW_VALID    = slow_valid_q;
    assign SLOW_CMD      = slow_cmd_q;
    assign SLOW_ADDR     = slow_addr_q;
    assign SLOW_DATA     = slow_data_q;
    assign FE_DATA       = fe_data_q;
    assign FE_DATA_VALID = fe_valid_q;
    assign FE_DATA_LAST  = fe_last_q;
    assign RUN_MODE      = run_mode_q;
    assign BUSY          = (state_q != IDLE);
    assign CMD_ERR       = cmd_err_q;
    assign ERR_CNT       = err_cnt_q;

endmodule

// File: tb/tb_fei4_cmd_decoder.sv
// Directed bench for fei4_cmd_decoder.
// Table of command streams plus hand sequences for WR_FE and reset.
module tb_fei4_cmd_decoder;

    logic        CMD_CLK;
    logic        RST_B;
    logic        CMD_DATA;
    logic [2:0]  CHIP_ID;
    logic        LV1, BCR, ECR, CAL;
    logic        SLOW_VALID;
    logic [3:0]  SLOW_CMD;
    logic [5:0]  SLOW_ADDR;
    logic [15:0] SLOW_DATA;
    logic [15:0] FE_DATA;
    logic        FE_DATA_VALID;
    logic        FE_DATA_LAST;
    logic        RUN_MODE;
    logic        BUSY;
    logic        CMD_ERR;
    logic [7:0]  ERR_CNT;

    int errors = 0;
    int checks = 0;

    fei4_cmd_decoder #(.WR_FE_BITS(672)) dut (
        .CMD_CLK(CMD_CLK), .RST_B(RST_B), .CMD_DATA(CMD_DATA),
        .CHIP_ID(CHIP_ID), .LV1(LV1), .BCR(BCR), .ECR(ECR), .CAL(CAL),
        .SLOW_VALID(SLOW_VALID), .SLOW_CMD(SLOW_CMD),
        .SLOW_ADDR(SLOW_ADDR), .SLOW_DATA(SLOW_DATA),
        .FE_DATA(FE_DATA), .FE_DATA_VALID(FE_DATA_VALID),
        .FE_DATA_LAST(FE_DATA_LAST), .RUN_MODE(RUN_MODE),
        .BUSY(BUSY), .CMD_ERR(CMD_ERR), .ERR_CNT(ERR_CNT)
    );

    initial CMD_CLK = 1'b0;
    always #5 CMD_CLK = ~CMD_CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // strobe mask order: LV1 BCR ECR CAL SLOW_VALID CMD_ERR
    localparam logic [5:0] M_LV1 = 6'b100000;
    localparam logic [5:0] M_BCR = 6'b010000;
    localparam logic [5:0] M_ECR = 6'b001000;
    localparam logic [5:0] M_CAL = 6'b000100;
    localparam logic [5:0] M_SV  = 6'b000010;
    localparam logic [5:0] M_ER  = 6'b000001;

    typedef struct {
        logic [63:0] bits;
        int          len;
        logic [2:0]  chip;
        logic [5:0]  stb;
        logic [3:0]  cmd;
        logic [5:0]  addr;
        logic [15:0] data;
        logic        rm;
        logic [7:0]  ec;
    } vec_t;

    localparam int NV = 17;
    vec_t tv [NV];

    function automatic vec_t mk(
        input logic [63:0] b, input int n, input logic [2:0] c,
        input logic [5:0] s, input logic [3:0] cm,
        input logic [5:0] a, input logic [15:0] d,
        input logic rm, input logic [7:0] ec);
        vec_t v;
        v.bits = b; v.len = n; v.chip = c; v.stb = s;
        v.cmd = cm; v.addr = a; v.data = d; v.rm = rm; v.ec = ec;
        return v;
    endfunction

    function automatic logic [5:0] stb_now();
        return {LV1, BCR, ECR, CAL, SLOW_VALID, CMD_ERR};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic b);
        CMD_DATA = b;
        @(posedge CMD_CLK);
        #1;
    endtask

    task automatic send_quiet(input logic [63:0] b, input int n);
        for (int i = n - 1; i >= 0; i--) tick(b[i]);
    endtask

    logic [6:0]  quiet;
    logic [15:0] wv;
    logic [63:0] fe_hdr;

    initial begin
        tv[0]  = mk(64'({4'b0000, 5'b11101}), 9, 3'd3, M_LV1,
                    4'd0, 6'd0, 16'h0, 1'b0, 8'd0);
        tv[1]  = mk(64'(4'b0000), 4, 3'd3, 6'b0,
                    4'd0, 6'd0, 16'h0, 1'b0, 8'd0);
        tv[2]  = mk(64'({5'b10110, 4'b0001}), 9, 3'd3, M_BCR,
                    4'd0, 6'd0, 16'h0, 1'b0, 8'd0);
        tv[3]  = mk(64'({5'b10110, 4'b0010}), 9, 3'd3, M_ECR,
                    4'd0, 6'd0, 16'h0, 1'b0, 8'd0);
        tv[4]  = mk(64'({5'b10110, 4'b0100}), 9, 3'd3, M_CAL,
                    4'd0, 6'd0, 16'h0, 1'b0, 8'd0);
        tv[5]  = mk(64'({5'b10110, 4'b0011}), 9, 3'd3, M_ER,
                    4'd0, 6'd0, 16'h0, 1'b0, 8'd1);
        tv[6]  = mk(64'({5'b10110, 4'b1000, 4'b0010, 4'b0011,
                         6'b011011, 16'hA5C3}), 39, 3'd3, M_SV,
                    4'd2, 6'd27, 16'hA5C3, 1'b0, 8'd1);
        tv[7]  = mk(64'({5'b10110, 4'b1000, 4'b0010, 4'b0010,
                         6'b011011, 16'h1234}), 39, 3'd3, 6'b0,
                    4'd0, 6'd0, 16'h0, 1'b0, 8'd1);
        tv[8]  = mk(64'({5'b10110, 4'b1000, 4'b0010, 4'b1010,
                         6'b000101, 16'h5A3C}), 39, 3'd3, M_SV,
                    4'd2, 6'd5, 16'h5A3C, 1'b0, 8'd1);
        tv[9]  = mk(64'({5'b10110, 4'b1000, 4'b0001, 4'b0101,
                         6'b001100}), 23, 3'd5, M_SV,
                    4'd1, 6'd12, 16'h0, 1'b0, 8'd1);
        tv[10] = mk(64'({5'b10110, 4'b1000, 4'b1010, 4'b0011,
                         6'b111000}), 23, 3'd3, M_SV,
                    4'd10, 6'd56, 16'h0, 1'b1, 8'd1);
        tv[11] = mk(64'({5'b10110, 4'b1000, 4'b1010, 4'b0011,
                         6'b101010}), 23, 3'd3, M_ER,
                    4'd0, 6'd0, 16'h0, 1'b1, 8'd2);
        tv[12] = mk(64'({5'b10110, 4'b1000, 4'b1010, 4'b0010,
                         6'b000111}), 23, 3'd3, 6'b0,
                    4'd0, 6'd0, 16'h0, 1'b1, 8'd2);
        tv[13] = mk(64'({5'b10110, 4'b1000, 4'b1000, 4'b0011,
                         6'b000000}), 23, 3'd3, M_SV,
                    4'd8, 6'd0, 16'h0, 1'b0, 8'd2);
        tv[14] = mk(64'({5'b10110, 4'b1000, 4'b1001, 4'b0011,
                         6'b001010}), 23, 3'd3, M_SV,
                    4'd9, 6'd10, 16'h0, 1'b0, 8'd2);
        tv[15] = mk(64'({5'b10110, 4'b1000, 4'b0111, 4'b0011,
                         6'b000000}), 23, 3'd3, M_ER,
                    4'd0, 6'd0, 16'h0, 1'b0, 8'd3);
        tv[16] = mk(64'(5'b11101), 5, 3'd3, M_LV1,
                    4'd0, 6'd0, 16'h0, 1'b0, 8'd3);

        RST_B = 1'b1;
        CMD_DATA = 1'b0;
        CHIP_ID = 3'd3;
        #1 RST_B = 1'b0;
        #2;
        chk("reset_strobes", 32'({stb_now(), FE_DATA_VALID,
            FE_DATA_LAST, RUN_MODE, BUSY}), 32'd0);
        chk("reset_fields", 32'({SLOW_CMD, SLOW_ADDR, SLOW_DATA}), 32'd0);
        chk("reset_err_cnt", 32'(ERR_CNT), 32'd0);
        @(negedge CMD_CLK);
        @(negedge CMD_CLK);
        RST_B = 1'b1;

        // BUSY rises with the fifth header bit and falls on completion
        send_quiet(64'(4'b1011), 4);
        chk("busy_before_hdr", 32'(BUSY), 32'd0);
        tick(1'b0);
        chk("busy_enter_field2", 32'(BUSY), 32'd1);
        send_quiet(64'(3'b000), 3);
        chk("busy_in_field2", 32'(BUSY), 32'd1);
        tick(1'b1);
        chk("bcr_hand", 32'(stb_now()), 32'(M_BCR));
        chk("busy_after_bcr", 32'(BUSY), 32'd0);

        for (int r = 0; r < NV; r++) begin
            CHIP_ID = tv[r].chip;
            quiet = '0;
            for (int i = tv[r].len - 1; i >= 0; i--) begin
                tick(tv[r].bits[i]);
                if (i != 0) quiet = quiet | {stb_now(), FE_DATA_VALID};
            end
            chk($sformatf("v%0d_early", r), 32'(quiet), 32'd0);
            chk($sformatf("v%0d_strobes", r), 32'(stb_now()),
                32'(tv[r].stb));
            if (tv[r].stb[1]) begin
                chk($sformatf("v%0d_cmd", r), 32'(SLOW_CMD),
                    32'(tv[r].cmd));
                chk($sformatf("v%0d_addr", r), 32'(SLOW_ADDR),
                    32'(tv[r].addr));
                chk($sformatf("v%0d_data", r), 32'(SLOW_DATA),
                    32'(tv[r].data));
            end
            chk($sformatf("v%0d_busy", r), 32'(BUSY), 32'd0);
            chk($sformatf("v%0d_run_mode", r), 32'(RUN_MODE),
                32'(tv[r].rm));
            chk($sformatf("v%0d_err_cnt", r), 32'(ERR_CNT),
                32'(tv[r].ec));
        end

        // error counter saturates
        CHIP_ID = 3'd3;
        for (int k = 0; k < 260; k++)
            send_quiet(64'({5'b10110, 4'b0011}), 9);
        chk("sat_strobe", 32'(stb_now()), 32'(M_ER));
        chk("sat_err_cnt", 32'(ERR_CNT), 32'd255);

        // full WR_FE: 42 words 0..41, payload holds 11101 and 10110
        fe_hdr = 64'({5'b10110, 4'b1000, 4'b0100, 4'b0011, 6'b000000});
        send_quiet(fe_hdr, 23);
        chk("fe_hdr_busy", 32'(BUSY), 32'd1);
        chk("fe_hdr_strobes", 32'(stb_now()), 32'd0);
        for (int k = 0; k < 42; k++) begin
            wv = 16'(k);
            for (int b = 15; b >= 0; b--) begin
                tick(wv[b]);
                if (b == 0) begin
                    chk($sformatf("fe_w%0d_valid", k),
                        32'(FE_DATA_VALID), 32'd1);
                    chk($sformatf("fe_w%0d_data", k),
                        32'(FE_DATA), 32'(k));
                    chk($sformatf("fe_w%0d_last", k),
                        32'(FE_DATA_LAST), 32'(k == 41));
                    chk($sformatf("fe_w%0d_strobes", k),
                        32'(stb_now()), (k == 41) ? 32'(M_SV) : 32'd0);
                end else begin
                    chk($sformatf("fe_w%0d_b%0d_idle", k, b),
                        32'({stb_now(), FE_DATA_VALID, FE_DATA_LAST}),
                        32'd0);
                end
            end
        end
        chk("fe_done_busy", 32'(BUSY), 32'd0);
        chk("fe_done_cmd", 32'(SLOW_CMD), 32'd4);
        chk("fe_done_data", 32'(SLOW_DATA), 32'd0);

        // reset in the middle of word 10 of a WR_FE
        send_quiet(64'({5'b10110, 4'b1000, 4'b1010, 4'b0011,
                        6'b111000}), 23);
        chk("pre_rst_run_mode", 32'(RUN_MODE), 32'd1);
        send_quiet(fe_hdr, 23);
        for (int k = 0; k < 10; k++) begin
            wv = 16'(k);
            for (int b = 15; b >= 0; b--) tick(wv[b]);
        end
        send_quiet(64'(5'b10101), 5);
        chk("pre_rst_busy", 32'(BUSY), 32'd1);
        chk("pre_rst_fe_data", 32'(FE_DATA), 32'd9);
        #2 RST_B = 1'b0;
        #1;
        chk("mid_rst_strobes", 32'({stb_now(), FE_DATA_VALID,
            FE_DATA_LAST, RUN_MODE, BUSY}), 32'd0);
        chk("mid_rst_fields", 32'({SLOW_CMD, SLOW_ADDR, SLOW_DATA}),
            32'd0);
        chk("mid_rst_fe_data", 32'(FE_DATA), 32'd0);
        chk("mid_rst_err_cnt", 32'(ERR_CNT), 32'd0);
        @(negedge CMD_CLK);
        RST_B = 1'b1;

        quiet = '0;
        for (int i = 4; i >= 0; i--) begin
            wv = 16'(5'b11101);
            tick(wv[i]);
            if (i != 0) quiet = quiet | {stb_now(), FE_DATA_VALID};
        end
        chk("post_rst_early", 32'(quiet), 32'd0);
        chk("post_rst_lv1", 32'(stb_now()), 32'(M_LV1));
        chk("post_rst_err_cnt", 32'(ERR_CNT), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
